// File: rtl/sort_stream4.sv
// Streaming odd-even transposition sorter: loads DEPTH words, sorts them in DEPTH passes, then emits them serially.
// Optional macro SORT_STREAM_DESCEND_EN flips the order to largest-first.
module sort_stream4 #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy
);

    localparam int unsigned IDX_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_SORT = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] mem      [DEPTH];
    logic [WIDTH-1:0] mem_pass [DEPTH];
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_d;
    logic [IDX_W-1:0] idx_inc;
    logic [IDX_W-1:0] pcnt;
    logic [IDX_W-1:0] pcnt_d;
    logic             in_ready_d;
    logic             out_valid_d;
    logic             out_last_d;
    logic [WIDTH-1:0] out_data_d;
    logic             busy_d;
    logic             mem_we;
    logic             sort_we;
    logic             in_hs;
    logic             out_hs;

    assign in_hs   = in_valid && in_ready;
    assign out_hs  = out_valid && out_ready;
    assign idx_inc = idx + IDX_W'(1);

    // Ordering predicate: true when the pair must be exchanged.
    function automatic logic swap_needed(input logic [WIDTH-1:0] lo, input logic [WIDTH-1:0] hi);
`ifdef SORT_STREAM_DESCEND_EN
        return lo < hi;
`else
        return lo > hi;
`endif
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_LOAD: if (in_hs && (idx == LAST_IDX)) state_next = ST_SORT;
            ST_SORT: if (pcnt == LAST_IDX) state_next = ST_OUT;
            ST_OUT:  if (out_hs && out_last) state_next = ST_LOAD;
            default: state_next = ST_LOAD;
        endcase
    end

    // One transposition pass; even passes pair (0,1),(2,3).., odd passes pair (1,2),(3,4)..
    always_comb begin
        mem_pass = mem;
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
            if ((i % 2) == int'(pcnt[0])) begin
                if (swap_needed(mem[i], mem[i+1])) begin
                    mem_pass[i]   = mem[i+1];
                    mem_pass[i+1] = mem[i];
                end
            end
        end
    end

    // Output and datapath next-values; every output is registered below.
    always_comb begin
        idx_d       = idx;
        pcnt_d      = pcnt;
        out_valid_d = out_valid;
        out_last_d  = out_last;
        out_data_d  = out_data;
        mem_we      = 1'b0;
        sort_we     = 1'b0;
        in_ready_d  = (state_next == ST_LOAD);
        busy_d      = (state_next != ST_LOAD);
        case (state)
            ST_LOAD: begin
                if (in_hs) begin
                    mem_we = 1'b1;
                    pcnt_d = '0;
                    idx_d  = (idx == LAST_IDX) ? '0 : idx_inc;
                end
            end
            ST_SORT: begin
                sort_we = 1'b1;
                pcnt_d  = pcnt + IDX_W'(1);
                if (pcnt == LAST_IDX) begin
                    pcnt_d = '0;
                    idx_d  = '0;
                end
            end
            ST_OUT: begin
                if (!out_valid) begin
                    out_valid_d = 1'b1;
                    out_data_d  = mem[idx];
                    out_last_d  = (idx == LAST_IDX);
                end else if (out_ready) begin
                    if (out_last) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        idx_d       = '0;
                    end else begin
                        idx_d      = idx_inc;
                        out_data_d = mem[idx_inc];
                        out_last_d = (idx_inc == LAST_IDX);
                    end
                end
            end
            default: begin
                idx_d  = '0;
                pcnt_d = '0;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            pcnt      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
        end else begin
            idx       <= idx_d;
            pcnt      <= pcnt_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            out_last  <= out_last_d;
            out_data  <= out_data_d;
            busy      <= busy_d;
        end
    end

    // Word storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= in_data;
        end else if (sort_we) begin
            mem <= mem_pass;
        end
    end

endmodule

// File: tb/tb_sort_stream4.sv
// Self-checking bench for sort_stream4: vector table plus hand-written timing, backpressure, gap and reset sequences.
module tb_sort_stream4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       busy;

    sort_stream4 #(.WIDTH(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][7:0] din;
        logic [3:0][7:0] exp;
    } vec_t;

    logic [7:0] sb[$];
    int total = 0;
    int bad   = 0;

    function automatic vec_t mk(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                                input logic [7:0] a3, input logic [7:0] e0, input logic [7:0] e1,
                                input logic [7:0] e2, input logic [7:0] e3);
        vec_t v;
        v.din[0] = a0; v.din[1] = a1; v.din[2] = a2; v.din[3] = a3;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected values are stored ascending; the descending build reverses them.
    task automatic push_exp(input vec_t v);
        for (int j = 0; j < 4; j++) begin
`ifdef SORT_STREAM_DESCEND_EN
            sb.push_back(v.exp[3-j]);
`else
            sb.push_back(v.exp[j]);
`endif
        end
    endtask

    task automatic send_word(input logic [7:0] v);
        int guard = 0;
        bit acc = 1'b0;
        in_data  = v;
        in_valid = 1'b1;
        while (!acc) begin
            acc = in_ready;
            step();
            guard++;
            if (!acc && guard > 50) begin
                check("send_timeout", 32'd0, 32'd1);
                acc = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_batch(input vec_t v);
        push_exp(v);
        for (int j = 0; j < 4; j++) send_word(v.din[j]);
    endtask

    // Drains one batch against the scoreboard; optional out_ready toggling and in_valid pokes.
    task automatic drain(input bit toggle, input bit poke);
        int n = 0;
        int cyc = 0;
        logic [7:0] e;
        while (n < 4 && cyc < 100) begin
            out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            if (poke) begin
                in_valid = cyc[0];
                in_data  = 8'hAA;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("out_data", 32'(out_data), 32'(e));
                end
                check("out_last", 32'(out_last), 32'(n == 3));
                check("in_ready_out", 32'(in_ready), 32'd0);
                n++;
            end
            step();
            cyc++;
        end
        if (n < 4) check("drain_timeout", 32'(n), 32'd4);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("post_out_valid", 32'(out_valid), 32'd0);
        check("post_in_ready", 32'(in_ready), 32'd1);
        check("post_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        int lat;
        vecs[0] = mk(8'd255, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255);
        vecs[1] = mk(8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9);
        vecs[2] = mk(8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 8'd2, 8'd3, 8'd4);
        vecs[3] = mk(8'd4, 8'd3, 8'd2, 8'd1, 8'd1, 8'd2, 8'd3, 8'd4);

        rst_n     = 1'b0;
        in_data   = 8'd0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Basic sort with latency and busy checks.
        send_batch(mk(8'd0, 8'd2, 8'd7, 8'd4, 8'd0, 8'd2, 8'd4, 8'd7));
        check("sort_busy", 32'(busy), 32'd1);
        check("sort_in_ready", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check("latency", 32'(lat), 32'd5);
        check("out_busy", 32'(busy), 32'd1);
        drain(1'b0, 1'b0);

        // Boundary vectors.
        for (int k = 0; k < 4; k++) begin
            send_batch(vecs[k]);
            drain(1'b0, 1'b0);
        end

        // Backpressure with in_valid pokes during OUT.
        send_batch(mk(8'd5, 8'd1, 8'd8, 8'd3, 8'd1, 8'd3, 8'd5, 8'd8));
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = 8'hEE;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(out_data), 32'(sb[0]));
            step();
        end
        in_valid = 1'b0;
        drain(1'b1, 1'b1);

        // Input gaps.
        push_exp(mk(8'd6, 8'd2, 8'd9, 8'd1, 8'd1, 8'd2, 8'd6, 8'd9));
        send_word(8'd6);
        step();
        step();
        send_word(8'd2);
        step();
        send_word(8'd9);
        send_word(8'd1);
        check("gap_in_ready", 32'(in_ready), 32'd0);
        drain(1'b0, 1'b0);

        // Asynchronous reset during SORT.
        for (int j = 0; j < 4; j++) send_word(8'(3 - ((j * 2) % 4) + (j == 3 ? -1 : 0)));
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_data", 32'(out_data), 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        send_batch(mk(8'd4, 8'd3, 8'd2, 8'd1, 8'd1, 8'd2, 8'd3, 8'd4));
        drain(1'b0, 1'b0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
